mrio_store_port: RTL and testbench

// Receiving end of the STO_IO store strobe produced by the store decoder.

---
 rtl/mrio_store_port_if.sv | 9 +
 rtl/mrio_store_port.sv | 73 +++++++
 tb/tb_mrio_store_port.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mrio_store_port_if.sv
// mrio_store_port_if: I/O bus handshake carrying the store FIFO head to the device
interface mrio_store_port_if #(parameter int PORT_W = 4, parameter int DATA_W = 16);
  logic              io_valid;
  logic [PORT_W-1:0] io_port;
  logic [DATA_W-1:0] io_data;
  logic              io_ack;
  modport master(output io_valid, io_port, io_data, input io_ack);
  modport slave(input io_valid, io_port, io_data, output io_ack);
endinterface

// File: rtl/mrio_store_port.sv
// mrio_store_port: queues STO_IO stores in a FIFO and presents them on the I/O bus
module mrio_store_port #(
  parameter int DEPTH  = 4,
  parameter int PORT_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sto_io,
  input  logic [15:0]              dst,
  input  logic [DATA_W-1:0]        d,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  input  logic                     ovf_clr,
  mrio_store_port_if.master        bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = PORT_W + DATA_W;
  typedef enum logic {IDLE, SEND} state_t;
  state_t            state;
  logic [W-1:0]      mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [PORT_W-1:0] port_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, push, pop;
  logic [AW:0]       count_nx;
  logic [W-1:0]      wr_word, head, nxt_head;
  assign push     = sto_io && !stall;
  assign pop      = valid_q && bus.io_ack;
  assign wr_word  = {dst[PORT_W+2:3], d};
  assign head     = mem[rptr];
  assign nxt_head = mem[rptr + AW'(1)];
  assign count_nx = (push && !pop) ? count + (AW+1)'(1) :
                    (pop && !push) ? count - (AW+1)'(1) : count;
  assign bus.io_valid = valid_q;
  assign bus.io_port  = port_q;
  assign bus.io_data  = data_q;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= wr_word;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      stall   <= 1'b0;
      ovf     <= 1'b0;
      state   <= IDLE;
      valid_q <= 1'b0;
      port_q  <= '0;
      data_q  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count_nx;
      stall <= count_nx == (AW+1)'(DEPTH);
      ovf   <= (sto_io && stall) || (ovf && !ovf_clr);
      // A store landing in an empty FIFO bypasses the memory read so it shows next cycle
      if (state == IDLE) begin
        if (count != '0 || push) begin
          state            <= SEND;
          valid_q          <= 1'b1;
          {port_q, data_q} <= (count != '0) ? head : wr_word;
        end
      end else if (bus.io_ack) begin
        if (count > (AW+1)'(1)) {port_q, data_q} <= nxt_head;
        else begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_mrio_store_port.sv
// tb_mrio_store_port: directed scoreboard bench for the I/O store port
module tb_mrio_store_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sto_io = 1'b0;
  logic [15:0] dst = '0;
  logic [15:0] d = '0;
  logic        stall, ovf;
  logic        ovf_clr = 1'b0;
  logic [2:0]  count;
  int          vectors = 0;
  int          miss = 0;
  logic [19:0] sb[$];
  mrio_store_port_if #(.PORT_W(4), .DATA_W(16)) bus();
  mrio_store_port #(.DEPTH(4), .PORT_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sto_io(sto_io), .dst(dst), .d(d),
    .stall(stall), .count(count), .ovf(ovf), .ovf_clr(ovf_clr), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model the edge about to happen, then advance past it
  task automatic cyc();
    logic [19:0] e;
    if (sto_io && !stall) sb.push_back({dst[6:3], d});
    if (bus.io_valid && bus.io_ack) begin
      if (sb.size() == 0) chk("pop_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("head", {12'h0, bus.io_port, bus.io_data}, {12'h0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] dv, input logic [15:0] pv);
    sto_io = 1'b1; dst = pv; d = dv;
    cyc();
    sto_io = 1'b0;
  endtask

  initial begin
    int pushes, n;
    bus.io_ack = 1'b0;
    repeat (2) cyc();
    chk("rst_count", count, 0);
    chk("rst_stall", stall, 0);
    chk("rst_valid", bus.io_valid, 0);
    chk("rst_port", bus.io_port, 0);
    chk("rst_data", bus.io_data, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    cyc();
    // single store, immediate ack
    bus.io_ack = 1'b1;
    store(16'hBEEF, 16'h0092);
    chk("t1_valid", bus.io_valid, 1);
    chk("t1_port", bus.io_port, 2);
    chk("t1_data", bus.io_data, 16'hBEEF);
    chk("t1_count", count, 1);
    cyc();
    chk("t1_idle", bus.io_valid, 0);
    chk("t1_empty", count, 0);
    // fill, overflow, overflow-clear priority, drain
    bus.io_ack = 1'b0;
    for (int i = 1; i <= 4; i++) store(16'(i), 16'(i << 3));
    chk("t2_stall", stall, 1);
    chk("t2_count", count, 4);
    store(16'd5, 16'h0028);
    chk("t2_ovf", ovf, 1);
    chk("t2_dropped", count, 4);
    sto_io = 1'b1; ovf_clr = 1'b1;
    cyc();
    sto_io = 1'b0;
    chk("t6_set_wins", ovf, 1);
    cyc();
    ovf_clr = 1'b0;
    chk("t6_cleared", ovf, 0);
    bus.io_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_no_bubble", bus.io_valid, 1);
      cyc();
    end
    chk("t2_drained", count, 0);
    chk("t2_idle", bus.io_valid, 0);
    chk("t2_sb_empty", sb.size(), 0);
    // output stability while stalled by the device
    bus.io_ack = 1'b0;
    store(16'h1234, 16'h0050);
    for (int i = 0; i < 10; i++) begin
      chk("t3_port_hold", bus.io_port, 4'hA);
      chk("t3_data_hold", bus.io_data, 16'h1234);
      cyc();
    end
    // ack the last entry while pushing: IDLE for one cycle, then the new entry
    bus.io_ack = 1'b1;
    store(16'h5555, 16'h0018);
    bus.io_ack = 1'b0;
    chk("t3_bubble", bus.io_valid, 0);
    chk("t3_count", count, 1);
    cyc();
    chk("t3_valid", bus.io_valid, 1);
    chk("t3_port", bus.io_port, 3);
    chk("t3_data", bus.io_data, 16'h5555);
    bus.io_ack = 1'b1;
    cyc();
    chk("t3_idle", bus.io_valid, 0);
    // simultaneous push/pop at COUNT=2, then random wrap-around traffic
    bus.io_ack = 1'b0;
    store(16'hA001, 16'h0008);
    store(16'hA002, 16'h0010);
    chk("t4_count2", count, 2);
    bus.io_ack = 1'b1;
    store(16'hA003, 16'h0020);
    chk("t4_hold2", count, 2);
    pushes = 0; n = 0;
    while (pushes < 12 && n < 400) begin
      sto_io = 1'($urandom_range(0, 1));
      dst = 16'($urandom); d = 16'($urandom);
      bus.io_ack = 1'($urandom_range(0, 1));
      if (sto_io && !stall) pushes++;
      cyc();
      n++;
    end
    chk("t4_pushes", pushes, 12);
    sto_io = 1'b0; bus.io_ack = 1'b1; n = 0;
    while (count != 0 && n < 20) begin
      cyc();
      n++;
    end
    chk("t4_drain", count, 0);
    chk("t4_sb_empty", sb.size(), 0);
    bus.io_ack = 1'b0; ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    // async reset mid-SEND
    for (int i = 0; i < 3; i++) store(16'(16'hC000 + i), 16'h0030);
    chk("t5_count3", count, 3);
    chk("t5_valid", bus.io_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", bus.io_valid, 0);
    chk("t5_rst_count", count, 0);
    sb.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    store(16'h7777, 16'h0078);
    chk("t5_new_valid", bus.io_valid, 1);
    chk("t5_new_port", bus.io_port, 4'hF);
    chk("t5_new_data", bus.io_data, 16'h7777);
    bus.io_ack = 1'b1;
    cyc();
    chk("t5_idle", bus.io_valid, 0);
    chk("t5_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
